// File: rtl/lcd_responder.sv
// lcd_responder
//   Behavioural stand-in for an HD44780-style character LCD controller.
//   It accepts instruction and data strobes from a writer and holds a
//   32-byte DDRAM (two rows of 16). Scanout logic reads that DDRAM through
//   an independent registered read port.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; restarts the DDRAM blanking
//   lcd_data    bus byte from the writer
//   lcd_ctrl    {rs, rw}: rs=1 data / rs=0 instruction, rw=1 read request
//   lcd_enable  write strobe; only its rising edge is acted on
//   rd_addr     scanout index, 0-15 row 0, 16-31 row 1
//   rd_data     registered DDRAM byte at rd_addr (one-cycle latency)
//   busy        high while an instruction, data write or clear is in progress
//   ac          DDRAM address counter (0x00-0x0F, 0x40-0x4F)
//   display_on, cursor_on, blink_on, entry_inc   display/entry-mode state
//   overrun     sticky: a strobe arrived while busy
//   rw_err      sticky: a read request was strobed (reads are not supported)

module lcd_responder #(
   parameter int BUSY_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] lcd_data,
   input  logic [1:0] lcd_ctrl,
   input  logic       lcd_enable,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic [6:0] ac,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic       overrun,
   output logic       rw_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] EXEC  = 2'd1;
   localparam logic [1:0] CLEAR = 2'd2;

   localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYCLES - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [4:0]    clr_idx;
   logic          en_q;
   logic [7:0]    mem [0:31];

   logic       rs, rw;
   logic       strobe, accept, data_wr;
   logic [6:0] ac_step;
   logic       mem_we;
   logic [4:0] mem_wa;
   logic [7:0] mem_wd;

   assign rs     = lcd_ctrl[1];
   assign rw     = lcd_ctrl[0];
   assign strobe = lcd_enable & ~en_q;
   // Only a write strobe landing in IDLE is decoded; anything else is dropped.
   assign accept  = strobe && (state == IDLE) && !rw;
   assign data_wr = accept && rs;
   assign busy    = (state != IDLE);

   // Address counter walks 0x00-0x0F and 0x40-0x4F, wrapping between rows.
   always_comb begin
      ac_step = ac;
      if (entry_inc) begin
         if (ac[3:0] == 4'hF) ac_step = ac[6] ? 7'h00 : 7'h40;
         else                 ac_step = ac + 7'd1;
      end else begin
         if (ac[3:0] == 4'h0) ac_step = ac[6] ? 7'h0F : 7'h4F;
         else                 ac_step = ac - 7'd1;
      end
   end

   // Single DDRAM write port, shared by data writes (IDLE only) and blanking
   // (CLEAR only), so the two sources never collide.
   always_comb begin
      mem_we = !rst && (data_wr || (state == CLEAR));
      mem_wa = (state == CLEAR) ? clr_idx : {ac[6], ac[3:0]};
      mem_wd = (state == CLEAR) ? 8'h20 : lcd_data;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   // Read-before-write: a same-cycle write to rd_addr shows up a cycle later.
   always_ff @(posedge clk) begin
      if (rst) rd_data <= 8'h00;
      else     rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         clr_idx    <= 5'd0;
         cnt        <= '0;
         en_q       <= 1'b0;
         ac         <= 7'h00;
         display_on <= 1'b0;
         cursor_on  <= 1'b0;
         blink_on   <= 1'b0;
         entry_inc  <= 1'b1;
         overrun    <= 1'b0;
         rw_err     <= 1'b0;
      end else begin
         en_q <= lcd_enable;
         if (strobe && (state != IDLE))     overrun <= 1'b1;
         if (strobe && (state == IDLE) && rw) rw_err <= 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  if (rs) begin
                     ac    <= ac_step;
                     state <= EXEC;
                     cnt   <= CNT_LOAD;
                  end else if (lcd_data == 8'h01) begin
                     ac        <= 7'h00;
                     entry_inc <= 1'b1;
                     clr_idx   <= 5'd0;
                     state     <= CLEAR;
                  end else begin
                     state <= EXEC;
                     cnt   <= CNT_LOAD;
                     // Highest set bit selects the instruction.
                     casez (lcd_data)
                        8'b1???????: ac <= {lcd_data[6], 2'b00, lcd_data[3:0]};
                        8'b00001???: begin
                           display_on <= lcd_data[2];
                           cursor_on  <= lcd_data[1];
                           blink_on   <= lcd_data[0];
                        end
                        8'b000001??: entry_inc <= lcd_data[1];
                        8'b0000001?: ac <= 7'h00;
                        default: ;  // CGRAM, function set, shift, no-op
                     endcase
                  end
               end
            end
            EXEC: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            CLEAR: begin
               if (clr_idx == 5'd31) state   <= IDLE;
               else                  clr_idx <= clr_idx + 5'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder
//   Directed bench for lcd_responder: reset blanking, address-counter
//   stepping and row wrap, instruction decode, overrun/rw_err flags,
//   clear timing and reset during clear.

module tb_lcd_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] lcd_data = 8'h00;
   logic [1:0] lcd_ctrl = 2'b00;
   logic       lcd_enable = 1'b0;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_data;
   logic       busy;
   logic [6:0] ac;
   logic       display_on, cursor_on, blink_on, entry_inc;
   logic       overrun, rw_err;

   int n_chk  = 0;
   int n_fail = 0;
   int n;

   lcd_responder #(.BUSY_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
      .lcd_enable(lcd_enable), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .ac(ac), .display_on(display_on), .cursor_on(cursor_on),
      .blink_on(blink_on), .entry_inc(entry_inc), .overrun(overrun),
      .rw_err(rw_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // One rising edge of lcd_enable; returns at the negedge of cycle N+1.
   task automatic strobe(input logic s_rs, input logic s_rw, input logic [7:0] d);
      @(negedge clk);
      lcd_ctrl   = {s_rs, s_rw};
      lcd_data   = d;
      lcd_enable = 1'b1;
      @(negedge clk);
      lcd_enable = 1'b0;
   endtask

   // Counts negedges until busy drops, bounded.
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("idle_reached", 8'(busy), 8'h00);
   endtask

   task automatic op(input logic s_rs, input logic [7:0] d);
      int c;
      strobe(s_rs, 1'b0, d);
      wait_idle(c);
   endtask

   task automatic rd(input string tag, input logic [4:0] idx, input logic [7:0] exp);
      @(negedge clk);
      rd_addr = idx;
      @(negedge clk);
      chk(tag, rd_data, exp);
   endtask

   initial begin
      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_ac",      8'(ac), 8'h00);
      chk("rst_busy",    8'(busy), 8'h01);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_inc",     8'(entry_inc), 8'h01);
      chk("rst_disp",    8'({display_on, cursor_on, blink_on}), 8'h00);
      chk("rst_flags",   8'({overrun, rw_err}), 8'h00);

      // ---- blanking after reset: 32 busy cycles ----
      rst = 1'b0;
      wait_idle(n);
      chk("rst_clear_len", 8'(n), 8'd32);
      for (int i = 0; i < 32; i++) rd("blank", 5'(i), 8'h20);

      // ---- set DDRAM address 0x45, write 'A' ----
      strobe(1'b0, 1'b0, 8'hC5);
      wait_idle(n);
      chk("exec_len", 8'(n), 8'd4);
      chk("ac_c5", 8'(ac), 8'h45);
      rd_addr = 5'd21;
      strobe(1'b1, 1'b0, 8'h41);
      chk("rdw_old", rd_data, 8'h20);       // same-cycle write returns old byte
      @(negedge clk);
      chk("rdw_new", rd_data, 8'h41);
      wait_idle(n);
      chk("ac_46", 8'(ac), 8'h46);
      rd("idx21", 5'd21, 8'h41);

      // ---- row wrap 0x0F -> 0x40 ----
      op(1'b0, 8'h8F);
      chk("ac_0f", 8'(ac), 8'h0F);
      op(1'b1, 8'h31);
      chk("ac_wrap40", 8'(ac), 8'h40);
      op(1'b1, 8'h32);
      chk("ac_41", 8'(ac), 8'h41);
      rd("idx15", 5'd15, 8'h31);
      rd("idx16", 5'd16, 8'h32);

      // ---- decrement mode wraps ----
      op(1'b0, 8'h04);
      chk("inc_off", 8'(entry_inc), 8'h00);
      op(1'b0, 8'h02);
      chk("home", 8'(ac), 8'h00);
      op(1'b1, 8'h58);
      chk("ac_dec4f", 8'(ac), 8'h4F);
      rd("idx0", 5'd0, 8'h58);
      op(1'b0, 8'hC0);
      op(1'b1, 8'h59);
      chk("ac_dec0f", 8'(ac), 8'h0F);
      rd("idx16b", 5'd16, 8'h59);
      op(1'b0, 8'h06);
      chk("inc_on", 8'(entry_inc), 8'h01);

      // ---- held enable is a single strobe ----
      @(negedge clk);
      lcd_ctrl = 2'b10; lcd_data = 8'h44; lcd_enable = 1'b1;
      repeat (8) @(negedge clk);
      lcd_enable = 1'b0;
      wait_idle(n);
      chk("held_ac", 8'(ac), 8'h40);
      chk("held_ovr", 8'(overrun), 8'h00);
      rd("idx15b", 5'd15, 8'h44);

      // ---- read request sets rw_err, no busy ----
      strobe(1'b1, 1'b1, 8'h99);
      chk("rw_err", 8'(rw_err), 8'h01);
      chk("rw_busy", 8'(busy), 8'h00);
      chk("rw_ac", 8'(ac), 8'h40);

      // ---- strobe during EXEC is dropped ----
      strobe(1'b0, 1'b0, 8'h0E);
      strobe(1'b1, 1'b0, 8'h77);
      chk("overrun", 8'(overrun), 8'h01);
      wait_idle(n);
      chk("disp_bits", 8'({display_on, cursor_on, blink_on}), 8'h06);
      chk("drop_ac", 8'(ac), 8'h40);
      rd("drop_idx16", 5'd16, 8'h59);

      // ---- clear instruction: 32 busy cycles ----
      op(1'b0, 8'h04);
      strobe(1'b0, 1'b0, 8'h01);
      wait_idle(n);
      chk("clear_len", 8'(n), 8'd32);
      chk("clear_ac", 8'(ac), 8'h00);
      chk("clear_inc", 8'(entry_inc), 8'h01);
      rd("clr21", 5'd21, 8'h20);
      rd("clr0", 5'd0, 8'h20);

      // ---- reset in the middle of a clear ----
      op(1'b1, 8'h55);
      op(1'b1, 8'h56);
      strobe(1'b0, 1'b0, 8'h01);
      repeat (4) @(negedge clk);
      chk("midclr_ac", 8'(ac), 8'h00);
      chk("sticky_ovr", 8'(overrun), 8'h01);
      chk("sticky_rw", 8'(rw_err), 8'h01);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_busy", 8'(busy), 8'h01);
      chk("rst2_flags", 8'({overrun, rw_err}), 8'h00);
      chk("rst2_disp", 8'(display_on), 8'h00);
      rst = 1'b0;
      wait_idle(n);
      chk("rst2_len", 8'(n), 8'd32);
      for (int i = 0; i < 32; i++) rd("blank2", 5'(i), 8'h20);
      chk("rst2_ovr", 8'(overrun), 8'h00);
      chk("rst2_rw", 8'(rw_err), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
